// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access pipeline stage:
//   - bus widths for EX->MEM, MEM->WB and MEM->RF (forwarding) bundles
//   - stall vector width, Stop/NoStop encodings and stall bit positions
//   - mem_op one-hot bit positions (MSB first: lb lbu lh lhu lw sb sh sw)
//   - load-data capture FSM state encodings
//   - packed struct overlay for the EX->MEM bundle, plus an is-load helper
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 150;
  localparam int MEM_TO_WB_WD = 136;
  localparam int MEM_TO_RF_WD = 104;
  localparam int HILO_WD      = 66;
  localparam int StallBus     = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Stall vector bit that freezes each pipeline register
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

  // mem_op bit positions
  localparam int OP_LB  = 7;
  localparam int OP_LBU = 6;
  localparam int OP_LH  = 5;
  localparam int OP_LHU = 4;
  localparam int OP_LW  = 3;
  localparam int OP_SB  = 2;
  localparam int OP_SH  = 1;
  localparam int OP_SW  = 0;

  // Capture FSM: FRESH = load in MEM and SRAM data still on the bus,
  // HELD = load stalled in MEM, data lives in the capture register.
  typedef enum logic [1:0] {
    CAP_EMPTY = 2'd0,
    CAP_FRESH = 2'd1,
    CAP_HELD  = 2'd2
  } cap_state_e;

  // EX->MEM bundle, MSB to LSB
  typedef struct packed {
    logic [7:0]         mem_op;
    logic [HILO_WD-1:0] hilo_bus;
    logic [31:0]        pc;
    logic               ram_en;
    logic [3:0]         ram_wen;
    logic               sel_rf_res;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [31:0]        ex_result;
  } ex_to_mem_t;

  function automatic logic is_load_op(input logic [7:0] op);
    return |op[OP_LB:OP_LW];
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational little-endian load alignment and extension.
// Ports:
//   mem_op  in  8   one-hot memory op (lb lbu lh lhu lw sb sh sw)
//   off     in  2   byte offset within the word (address[1:0])
//   rdata   in  32  word read from the data SRAM
//   data    out 32  aligned, sign/zero-extended load data (0 for non-loads)
// Halfword accesses use off[1] only; lw ignores the offset entirely.
// -----------------------------------------------------------------------------
module load_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  mem_op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lanes[off];
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = 32'd0;
    if (mem_op[OP_LB])       data = {{24{byte_sel[7]}}, byte_sel};
    else if (mem_op[OP_LBU]) data = {24'd0, byte_sel};
    else if (mem_op[OP_LH])  data = {{16{half_sel[15]}}, half_sel};
    else if (mem_op[OP_LHU]) data = {16'd0, half_sel};
    else if (mem_op[OP_LW])  data = rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage between execute and write-back. Registers the
// EX->MEM bundle, aligns/extends synchronous data-SRAM read data for loads,
// selects the register-file write data and passes HI/LO through unchanged.
// A one-entry capture register keeps the SRAM read response alive while a
// load is stalled in MEM, since the SRAM only presents it for one cycle.
// Ports:
//   clk              in  1             clock
//   resetn           in  1             asynchronous active-low reset
//   stall            in  6             stall vector (bit3 EX/MEM, bit4 MEM/WB)
//   ex_to_mem_bus    in  EX_TO_MEM_WD  execute-stage result bundle
//   data_sram_rdata  in  32            SRAM read data, cycle after request
//   mem_to_wb_bus    out MEM_TO_WB_WD  {hilo, pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_rf_bus    out MEM_TO_RF_WD  {hilo, rf_we, rf_waddr, rf_wdata}
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

  ex_to_mem_t ex_in;
  ex_to_mem_t r_reg;
  cap_state_e state_reg;
  logic [31:0] hold_reg;

  logic stop_ex;
  logic stop_wb;
  logic bubble;
  logic advance;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  assign ex_in   = ex_to_mem_t'(ex_to_mem_bus);
  assign stop_ex = (stall[STALL_EX_MEM] == Stop);
  assign stop_wb = (stall[STALL_MEM_WB] == Stop);
  // EX frozen while WB moves on: insert an empty slot instead of duplicating
  assign bubble  = stop_ex & ~stop_wb;
  assign advance = ~stop_ex;

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_reg <= '0;
    end else if (bubble) begin
      r_reg <= '0;
    end else if (advance) begin
      r_reg <= ex_in;
    end
  end

  // Capture FSM: on the first held cycle of a load the SRAM data is still
  // valid, so it is copied into hold_reg and used until r_reg moves again.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= CAP_EMPTY;
      hold_reg  <= 32'd0;
    end else if (bubble) begin
      state_reg <= CAP_EMPTY;
    end else if (advance) begin
      // a new load always starts FRESH, discarding any held word
      state_reg <= is_load_op(ex_in.mem_op) ? CAP_FRESH : CAP_EMPTY;
    end else begin
      case (state_reg)
        CAP_FRESH: begin
          hold_reg  <= data_sram_rdata;
          state_reg <= CAP_HELD;
        end
        CAP_HELD:  state_reg <= CAP_HELD;
        default:   state_reg <= CAP_EMPTY;
      endcase
    end
  end

  assign rdata_eff = (state_reg == CAP_HELD) ? hold_reg : data_sram_rdata;

  load_align u_load_align (
    .mem_op (r_reg.mem_op),
    .off    (r_reg.ex_result[1:0]),
    .rdata  (rdata_eff),
    .data   (load_data)
  );

  assign rf_wdata = r_reg.sel_rf_res ? load_data : r_reg.ex_result;

  assign mem_to_wb_bus = {r_reg.hilo_bus, r_reg.pc, r_reg.rf_we, r_reg.rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {r_reg.hilo_bus, r_reg.rf_we, r_reg.rf_waddr, rf_wdata};

  // Fields and stall bits that have no function in this stage
  logic unused_bits;
  assign unused_bits = ^{stall[5], stall[2:0], r_reg.ram_en, r_reg.ram_wen};

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed stimulus for mem_stage with a scoreboard. The driver pushes the
// expected output bundle for each cycle into a queue; a monitor pops one entry
// per cycle on the falling edge and compares both output buses.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic [5:0]   stall;
  logic [149:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [135:0] mem_to_wb_bus;
  logic [103:0] mem_to_rf_bus;

  int checks = 0;
  int fails  = 0;

  bit           chk_q  [$];
  logic [135:0] exp_q  [$];
  string        name_q [$];

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus)
  );

  always #5 clk = ~clk;

  // {mem_op, hilo, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
  function automatic logic [149:0] mk_ex(input logic [7:0] op, input logic [65:0] hilo,
                                         input logic [31:0] pc, input logic sel,
                                         input logic we, input logic [4:0] wa,
                                         input logic [31:0] res);
    return {op, hilo, pc, |op, 4'b0000, sel, we, wa, res};
  endfunction

  function automatic logic [135:0] mk_wb(input logic [65:0] hilo, input logic [31:0] pc,
                                         input logic we, input logic [4:0] wa,
                                         input logic [31:0] wd);
    return {hilo, pc, we, wa, wd};
  endfunction

  // One cycle: drive next EX bundle / stall (sampled at the coming edge) and
  // the SRAM word for the instruction currently in MEM; queue its expectation.
  task automatic step(input logic [149:0] nxt, input logic [5:0] stl,
                      input logic [31:0] rd, input bit chk,
                      input logic [135:0] exp_wb, input string name);
    @(posedge clk);
    #1;
    ex_to_mem_bus   = nxt;
    stall           = stl;
    data_sram_rdata = rd;
    chk_q.push_back(chk);
    exp_q.push_back(exp_wb);
    name_q.push_back(name);
  endtask

  task automatic check_now(input logic [135:0] exp_wb, input string name);
    logic [103:0] exp_rf;
    exp_rf = {exp_wb[135:70], exp_wb[37:0]};
    checks++;
    if (mem_to_wb_bus !== exp_wb) begin
      fails++;
      $display("FAIL %s wb: got %h expected %h", name, mem_to_wb_bus, exp_wb);
    end
    checks++;
    if (mem_to_rf_bus !== exp_rf) begin
      fails++;
      $display("FAIL %s rf: got %h expected %h", name, mem_to_rf_bus, exp_rf);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (chk_q.size() > 0) begin
        bit c;
        logic [135:0] e;
        string n;
        c = chk_q.pop_front();
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (c) begin
          check_now(e, n);
          $display("txn %-16s wb=%h", n, mem_to_wb_bus);
        end
      end
    end
  end

  localparam logic [7:0] LB  = 8'h80;
  localparam logic [7:0] LBU = 8'h40;
  localparam logic [7:0] LH  = 8'h20;
  localparam logic [7:0] LHU = 8'h10;
  localparam logic [7:0] LW  = 8'h08;
  localparam logic [7:0] SW  = 8'h01;
  localparam logic [5:0] S_NONE   = 6'b000000;
  localparam logic [5:0] S_HOLD   = 6'b011000;
  localparam logic [5:0] S_BUBBLE = 6'b001000;

  initial begin
    logic [149:0] nop, i_lb, i_lbu1, i_lbu3, i_lhu2, i_lh2, i_lh3, i_lw, i_lwh;
    logic [149:0] i_lw2, i_alu, i_sw, i_lwr;
    logic [65:0]  hilo;
    logic [135:0] e_lb, z;

    hilo   = 66'h2_CAFE_F00D_1234_5678;
    nop    = '0;
    z      = '0;
    i_lb   = mk_ex(LB,  '0, 32'hBFC0_0010, 1'b1, 1'b1, 5'd5,  32'h0000_1003);
    i_lbu1 = mk_ex(LBU, '0, 32'hBFC0_0014, 1'b1, 1'b1, 5'd6,  32'h0000_2001);
    i_lbu3 = mk_ex(LBU, '0, 32'hBFC0_0018, 1'b1, 1'b1, 5'd7,  32'h0000_2003);
    i_lhu2 = mk_ex(LHU, '0, 32'hBFC0_001C, 1'b1, 1'b1, 5'd8,  32'h0000_3002);
    i_lh2  = mk_ex(LH,  '0, 32'hBFC0_0020, 1'b1, 1'b1, 5'd9,  32'h0000_3002);
    i_lh3  = mk_ex(LH,  '0, 32'hBFC0_0024, 1'b1, 1'b1, 5'd10, 32'h0000_3003);
    i_lw   = mk_ex(LW,  '0, 32'hBFC0_0028, 1'b1, 1'b1, 5'd11, 32'h0000_3002);
    i_lwh  = mk_ex(LW,  '0, 32'hBFC0_002C, 1'b1, 1'b1, 5'd12, 32'h0000_4000);
    i_lw2  = mk_ex(LW,  '0, 32'hBFC0_0030, 1'b1, 1'b1, 5'd13, 32'h0000_4004);
    i_alu  = mk_ex(8'h00, hilo, 32'hBFC0_0034, 1'b0, 1'b1, 5'd14, 32'hDEAD_BEEF);
    i_sw   = mk_ex(SW,  '0, 32'hBFC0_0038, 1'b0, 1'b0, 5'd0,  32'h0000_0ABC);
    i_lwr  = mk_ex(LW,  '0, 32'hBFC0_003C, 1'b1, 1'b1, 5'd15, 32'h0000_5000);
    e_lb   = mk_wb('0, 32'hBFC0_0010, 1'b1, 5'd5, 32'hFFFF_FF80);

    resetn          = 1'b0;
    stall           = S_NONE;
    ex_to_mem_bus   = nop;
    data_sram_rdata = 32'h0;
    #12;
    check_now(z, "reset_state");
    @(posedge clk);
    #3;
    resetn = 1'b1;

    step(i_lb,   S_NONE, 32'h0,         1, z,    "idle");
    step(i_lbu1, S_NONE, 32'h80FF_7F01, 1, e_lb, "lb_off3");
    step(i_lbu3, S_NONE, 32'h80FF_7F01, 1, mk_wb('0, 32'hBFC0_0014, 1, 5'd6,  32'h0000_007F), "lbu_off1");
    step(i_lhu2, S_NONE, 32'h80FF_7F01, 1, mk_wb('0, 32'hBFC0_0018, 1, 5'd7,  32'h0000_0080), "lbu_off3");
    step(i_lh2,  S_NONE, 32'hBEEF_1234, 1, mk_wb('0, 32'hBFC0_001C, 1, 5'd8,  32'h0000_BEEF), "lhu_off2");
    step(i_lh3,  S_NONE, 32'hBEEF_1234, 1, mk_wb('0, 32'hBFC0_0020, 1, 5'd9,  32'hFFFF_BEEF), "lh_off2");
    step(i_lw,   S_NONE, 32'hBEEF_1234, 1, mk_wb('0, 32'hBFC0_0024, 1, 5'd10, 32'hFFFF_BEEF), "lh_off3");
    step(i_lwh,  S_NONE, 32'hBEEF_1234, 1, mk_wb('0, 32'hBFC0_0028, 1, 5'd11, 32'hBEEF_1234), "lw_off2");
    // lw stalled in MEM for three edges; SRAM word changes after the first
    step(nop,    S_HOLD, 32'h1111_1111, 1, mk_wb('0, 32'hBFC0_002C, 1, 5'd12, 32'h1111_1111), "hold_c0");
    step(nop,    S_HOLD, 32'h2222_2222, 1, mk_wb('0, 32'hBFC0_002C, 1, 5'd12, 32'h1111_1111), "hold_c1");
    step(nop,    S_HOLD, 32'h2222_2222, 1, mk_wb('0, 32'hBFC0_002C, 1, 5'd12, 32'h1111_1111), "hold_c2");
    step(i_lw2,  S_NONE, 32'h2222_2222, 1, mk_wb('0, 32'hBFC0_002C, 1, 5'd12, 32'h1111_1111), "hold_c3");
    // new load replaces HELD, then a bubble drops the queued ALU op
    step(i_alu,  S_BUBBLE, 32'h3333_3333, 1, mk_wb('0, 32'hBFC0_0030, 1, 5'd13, 32'h3333_3333), "load_after_held");
    step(i_alu,  S_NONE, 32'h4444_4444, 1, z, "bubble");
    step(i_sw,   S_NONE, 32'h0,         1, mk_wb(hilo, 32'hBFC0_0034, 1, 5'd14, 32'hDEAD_BEEF), "alu_hilo");
    step(i_lwr,  S_NONE, 32'h0,         1, mk_wb('0, 32'hBFC0_0038, 0, 5'd0, 32'h0000_0ABC), "store_pass");
    step(nop,    S_HOLD, 32'h5555_5555, 1, mk_wb('0, 32'hBFC0_003C, 1, 5'd15, 32'h5555_5555), "pre_reset");
    step(nop,    S_HOLD, 32'h6666_6666, 1, mk_wb('0, 32'hBFC0_003C, 1, 5'd15, 32'h5555_5555), "held_pre_reset");
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_now(z, "async_reset");
    step(i_lb,   S_NONE, 32'h0,         1, z,    "in_reset");
    #2;
    resetn = 1'b1;
    step(nop,    S_NONE, 32'h80FF_7F01, 1, e_lb, "lb_after_reset");
    step(nop,    S_NONE, 32'h0,         1, z,    "final_idle");
    @(negedge clk);
    #1;
    checks++;
    if (chk_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", chk_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
